hex_line_encoder: RTL and testbench

Turns parallel ADC sample words into ASCII hex text lines for the UART debug path. It sits between the sample capture logic and the UART transmitter. Each accepted sample set is emitted one byte per handshake as upper- or lowercase hex digits, channels separated by a configurable character, and the line terminated with CR LF. It generalises the single-nibble ASCII encoder with these additions:

- parametrised sample width and channel count;
- a case mode;
- valid/ready flow control on both sides.

---
 rtl/hex_line_encoder.sv | 143 ++++++++++++++
 tb/tb_hex_line_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_line_encoder.sv
// Serialises parallel sample sets into ASCII hex text lines: channel digits MSB first,
// a separator between channels, and CR LF at the end. Valid/ready on both sides.
module hex_line_encoder #(
    parameter int         DATA_WIDTH   = 12,
    parameter int         NUM_CHANNELS = 1,
    parameter logic [7:0] SEPARATOR    = 8'h2C,
    parameter bit         LOWERCASE    = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [7:0]                         out_code,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy
);
    localparam int DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int PW     = DIGITS * 4;
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [DW-1:0] D_TOP  = DW'(DIGITS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_DIGIT, S_SEP, S_CR, S_LF} state_t;

    state_t                            r_state;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_data;
    logic [DW-1:0]                     r_d;
    logic [CW-1:0]                     r_c;
    logic [7:0]                        r_code;
    logic                              r_valid;

    logic [NUM_CHANNELS*DATA_WIDTH-1:0] w_src;
    logic [PW-1:0]                     w_chan [NUM_CHANNELS];
    logic [CW-1:0]                     w_sel_c;
    logic [DW-1:0]                     w_sel_d;
    logic [3:0]                        w_nib;
    logic [7:0]                        w_code;
    logic                              w_xfer;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'b0, nib};
        else
            return (LOWERCASE ? 8'h57 : 8'h37) + {4'b0, nib};
    endfunction

    // In IDLE the first digit is taken straight from in_data so it can load on the accept edge.
    assign w_src = (r_state == S_IDLE) ? in_data : r_data;

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign w_chan[gi] = PW'(w_src[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    // Select the nibble of the byte that follows the one currently presented.
    always_comb begin
        w_sel_c = '0;
        w_sel_d = D_TOP;
        case (r_state)
            S_DIGIT: begin
                w_sel_c = r_c;
                w_sel_d = r_d - 1'b1;
            end
            S_SEP:   w_sel_c = r_c + 1'b1;
            default: ;
        endcase
    end

    assign w_nib  = w_chan[w_sel_c][{w_sel_d, 2'b00} +: 4];
    assign w_code = to_ascii(w_nib);
    assign w_xfer = r_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_d     <= D_TOP;
            r_c     <= '0;
            r_code  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_state <= S_DIGIT;
                        r_d     <= D_TOP;
                        r_c     <= '0;
                        r_code  <= w_code;
                        r_valid <= 1'b1;
                    end
                end
                S_DIGIT: begin
                    if (w_xfer) begin
                        if (r_d != '0) begin
                            r_d    <= r_d - 1'b1;
                            r_code <= w_code;
                        end else if (r_c != C_LAST) begin
                            r_state <= S_SEP;
                            r_code  <= SEPARATOR;
                        end else begin
                            r_state <= S_CR;
                            r_code  <= 8'h0D;
                        end
                    end
                end
                S_SEP: begin
                    if (w_xfer) begin
                        r_state <= S_DIGIT;
                        r_c     <= r_c + 1'b1;
                        r_d     <= D_TOP;
                        r_code  <= w_code;
                    end
                end
                S_CR: begin
                    if (w_xfer) begin
                        r_state <= S_LF;
                        r_code  <= 8'h0A;
                    end
                end
                S_LF: begin
                    if (w_xfer) begin
                        r_state <= S_IDLE;
                        r_code  <= 8'h00;
                        r_valid <= 1'b0;
                        r_d     <= D_TOP;
                        r_c     <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_code  = r_code;
    assign out_valid = r_valid;
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_hex_line_encoder.sv
// Directed bench for hex_line_encoder: three instances cover uppercase 12-bit,
// lowercase 12-bit and a 3-channel 10-bit configuration.
module tb_hex_line_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din_a, din_b;
    logic [29:0] din_c;
    logic        iv  [3];
    logic        ir  [3];
    logic        ov  [3];
    logic        orr [3];
    logic        bz  [3];
    logic [7:0]  oc  [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    hex_line_encoder #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .SEPARATOR(8'h2C), .LOWERCASE(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_data(din_a), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_code(oc[0]), .out_valid(ov[0]), .out_ready(orr[0]), .busy(bz[0]));

    hex_line_encoder #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .SEPARATOR(8'h2C), .LOWERCASE(1'b1)) u_b (
        .clk(clk), .rst(rst), .in_data(din_b), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_code(oc[1]), .out_valid(ov[1]), .out_ready(orr[1]), .busy(bz[1]));

    hex_line_encoder #(.DATA_WIDTH(10), .NUM_CHANNELS(3), .SEPARATOR(8'h2C), .LOWERCASE(1'b0)) u_c (
        .clk(clk), .rst(rst), .in_data(din_c), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_code(oc[2]), .out_valid(ov[2]), .out_ready(orr[2]), .busy(bz[2]));

    task automatic check_idle(input int sel, input string tag);
        n_checks++;
        if (ov[sel] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_out_valid dut=%0d got=%b expected=0", tag, sel, ov[sel]);
        end
        n_checks++;
        if (ir[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready dut=%0d got=%b expected=1", tag, sel, ir[sel]);
        end
        n_checks++;
        if (bz[sel] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy dut=%0d got=%b expected=0", tag, sel, bz[sel]);
        end
    endtask

    task automatic start_line(input int sel, input logic [29:0] data);
        case (sel)
            0:       din_a = data[11:0];
            1:       din_b = data[11:0];
            default: din_c = data;
        endcase
        iv[sel] = 1'b1;
        @(posedge clk); #1;
        iv[sel] = 1'b0;
        n_checks++;
        if (ov[sel] !== 1'b1 || bz[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_latency dut=%0d out_valid=%b busy=%b expected 1/1", sel, ov[sel], bz[sel]);
        end
    endtask

    // mode 0: ready always high; 1: stall 10 cycles after 2nd byte then toggle;
    // 2: ready high while a different sample is offered on in_valid throughout.
    task automatic collect(input int sel, input int n, input int mode, input bit check_end);
        int t = 0;
        int s = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_code = 8'h00;
        got.delete();
        while (t < n && cyc < 400) begin
            if (mode == 1 && t >= 2) begin
                orr[sel] = (s < 10) ? 1'b0 : ((s - 10) % 2 == 1);
                s++;
            end else begin
                orr[sel] = 1'b1;
            end
            if (mode == 2) begin
                din_a   = 12'h777;
                iv[sel] = !(ov[sel] && oc[sel] == 8'h0A);
            end
            if (prev_stall) begin
                n_checks++;
                if (oc[sel] !== prev_code) begin
                    n_fail++;
                    $display("FAIL stall_hold dut=%0d got=%h expected=%h", sel, oc[sel], prev_code);
                end
            end
            if (ov[sel] === 1'b1) begin
                n_checks++;
                if (ir[sel] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_during_line dut=%0d got=%b expected=0", sel, ir[sel]);
                end
            end
            prev_stall = (ov[sel] === 1'b1) && !orr[sel];
            prev_code  = oc[sel];
            if (ov[sel] === 1'b1 && orr[sel]) begin
                got.push_back(oc[sel]);
                $display("dut=%0d byte %0d = %h", sel, t, oc[sel]);
                t++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv[sel]  = 1'b0;
        orr[sel] = 1'b1;
        n_checks++;
        if (t < n) begin
            n_fail++;
            $display("FAIL line_timeout dut=%0d got=%0d bytes expected=%0d", sel, t, n);
        end
        if (check_end) check_idle(sel, "after_lf");
    endtask

    task automatic compare_bytes(input string tag);
        n_checks++;
        if (got.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_length got=%0d expected=%0d", tag, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d got=%h expected=%h", tag, i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_idle(k, "reset");
            n_checks++;
            if (oc[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_out_code dut=%0d got=%h expected=00", k, oc[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_upper();
        start_line(0, 30'h0A5C);
        collect(0, 5, 0, 1'b1);
        exp_q = {8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A};
        compare_bytes("upper");
    endtask

    task automatic test_lowercase();
        start_line(1, 30'h00F3);
        collect(1, 5, 0, 1'b1);
        exp_q = {8'h30, 8'h66, 8'h33, 8'h0D, 8'h0A};
        compare_bytes("lower");
    endtask

    task automatic test_multichannel();
        start_line(2, {10'h3FF, 10'h001, 10'h200});
        collect(2, 13, 0, 1'b1);
        exp_q = {8'h32, 8'h30, 8'h30, 8'h2C, 8'h30, 8'h30, 8'h31, 8'h2C,
                 8'h33, 8'h46, 8'h46, 8'h0D, 8'h0A};
        compare_bytes("multi");
    endtask

    task automatic test_backpressure();
        start_line(0, 30'h0A5C);
        collect(0, 5, 1, 1'b1);
        exp_q = {8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A};
        compare_bytes("backpressure");
    endtask

    task automatic test_busy_ignored();
        start_line(0, 30'h0A5C);
        collect(0, 5, 2, 1'b1);
        exp_q = {8'h41, 8'h35, 8'h43, 8'h0D, 8'h0A};
        compare_bytes("busy_ignored");
        @(posedge clk); #1;
        check_idle(0, "no_late_accept");
        start_line(0, 30'h0777);
        collect(0, 5, 0, 1'b1);
        exp_q = {8'h37, 8'h37, 8'h37, 8'h0D, 8'h0A};
        compare_bytes("after_busy");
    endtask

    task automatic test_reset_midline();
        start_line(0, 30'h0A5C);
        collect(0, 2, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(0, "midline_reset");
        n_checks++;
        if (oc[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL midline_reset_out_code got=%h expected=00", oc[0]);
        end
        start_line(0, 30'h0123);
        collect(0, 5, 0, 1'b1);
        exp_q = {8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
        compare_bytes("after_reset");
    endtask

    initial begin
        rst   = 1'b1;
        din_a = '0;
        din_b = '0;
        din_c = '0;
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b1;
        end
        test_reset();
        test_single_upper();
        test_lowercase();
        test_multichannel();
        test_backpressure();
        test_busy_ignored();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
